radiometer_frame_packer: RTL and testbench
==========================================

Name: radiometer_frame_packer

Overview:
- Parametrised successor to the single-channel sample-to-UART path.
- Captures an N_CH-channel radiometer sample set, optionally decimated, and serialises it as a byte frame: sync byte, sequence number, big-endian 16-bit channel words, 8-bit checksum.
- Sits between the ADC/denoise stage and uart_tx, using a valid/ready byte handshake in place of a free-running start.
- Counts sample sets lost to backpressure.

Parameters:
- N_CH, 2, number of channels per sample set (1..8).
- DATA_W, 12, bits per channel sample (1..16), zero-extended to 16 bits on the wire.
- DECIM, 1, send one frame per DECIM sample_valid pulses (1..256).
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  permits new frames; sampled on each sample_valid.
- sample_valid  in  1  one-cycle strobe; sample_data valid this cycle.
- sample_data  in  N_CH*DATA_W  channel 0 in the LSBs.
- tx_ready  in  1  UART can accept a byte this cycle (uart_tx not busy).
- tx_valid  out  1  tx_byte is valid.
- tx_byte  out  8  current frame byte.
- frame_busy  out  1  high from capture until the checksum byte is transferred.
- drop_count  out  16  saturating count of dropped sample sets.

Behaviour:
- Reset values:
  - tx_valid=0, tx_byte=0, frame_busy=0, drop_count=0.
  - seq=0, decimation counter=0, state=IDLE.
  - Reset mid-frame aborts the frame at the next edge. No partial bytes follow.
- Decimation counter:
  - Increments on each sample_valid while enable=1.
  - On the pulse where counter==DECIM-1 (the terminal pulse), the counter returns to 0.
  - With enable=0, sample_valid is ignored and the counter holds.
- Terminal pulse:
  - If state==IDLE: latch sample_data, go to SYNC, frame_busy=1.
  - Otherwise: the sample set is not captured and drop_count increments, saturating at 16'hFFFF.
  - Non-terminal pulses never count as drops.
- Latency: a terminal sample_valid in IDLE at edge t gives tx_valid=1 with tx_byte=SYNC_BYTE after edge t+1.
- Byte handshake:
  - A byte transfers on any edge where tx_valid & tx_ready.
  - tx_byte and tx_valid hold while tx_ready=0.
  - After a transfer, the next byte is presented in the following cycle, so tx_valid stays high within a frame.
- State machine:
  - IDLE, then SYNC (SYNC_BYTE), then SEQ (seq).
  - DATA: 2*N_CH bytes in order ch0 MSB, ch0 LSB, ch1 MSB, and so on.
  - CSUM (checksum), then back to IDLE.
  - Each state advances only on a transfer.
- Frame length: 3+2*N_CH bytes.
- Checksum: mod-256 sum of the SEQ byte and all DATA bytes. SYNC_BYTE is excluded.
- seq:
  - Increments by 1 (mod 256) when the CSUM byte transfers.
  - Holds on drops and aborts.
- Leaving IDLE:
  - Transfer of CSUM returns to IDLE and drops frame_busy the next cycle.
  - A terminal pulse arriving in the same cycle as the CSUM transfer is a drop.
- enable=0 mid-frame: the current frame completes normally. No new frame starts.
- Latched data is immune to sample_data changes during the frame.

Test Plan:
1. N_CH=2, DATA_W=12, tx_ready=1, enable=1, one sample_valid with ch0=0xABC, ch1=0x123 -> bytes A5 00 0A BC 01 23 EA on 7 consecutive transfers; frame_busy then falls; seq=1.
2. Backpressure: as scenario 1, but tx_ready=0 for 5 cycles while byte BC is presented -> tx_byte holds BC and tx_valid=1 throughout; the stream is otherwise identical and no byte is duplicated.
3. Drop: second sample_valid three cycles after the first, during the frame -> frame bytes unchanged; drop_count=1; no second frame.
4. Decimation: DECIM=4, eight sample_valid pulses spaced 20 cycles, tx_ready=1 -> exactly 2 frames; data taken from pulses 4 and 8; seq 00 then 01; drop_count=0.
5. Wrap and saturation: 257 back-to-back frames -> seq bytes 00..FF then 00. Forcing 65 537 drops -> drop_count saturates at FFFF.
6. Reset during DATA byte 2 -> after the next edge tx_valid=0, frame_busy=0, drop_count=0. The next frame has seq=00 and a correct checksum.

Source files
------------

// File: rtl/radiometer_frame_packer.sv
// ---------------------------------------------------------------------------
// radiometer_frame_packer
//
// Captures one N_CH-channel radiometer sample set (optionally decimated) and
// serialises it as a byte frame toward a UART transmitter:
//
//   SYNC_BYTE | seq | ch0[15:8] ch0[7:0] ... chN-1[15:8] chN-1[7:0] | csum
//
// Channel samples are zero-extended from DATA_W to 16 bits. The checksum is
// the mod-256 sum of the seq byte and every data byte. SYNC_BYTE is excluded.
// Sample sets that arrive on a terminal decimation pulse while a frame is
// still in flight are dropped and counted in a saturating 16-bit counter.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   enable       in   permits new frames; qualifies sample_valid
//   sample_valid in   one-cycle strobe, sample_data valid this cycle
//   sample_data  in   N_CH*DATA_W, channel 0 in the LSBs
//   tx_ready     in   downstream can take a byte this cycle
//   tx_valid     out  tx_byte is valid
//   tx_byte      out  current frame byte
//   frame_busy   out  high from capture until the checksum byte transfers
//   drop_count   out  saturating count of dropped sample sets
//
// State table:
//   state   | meaning
//   S_IDLE  | no frame in flight, waiting for a terminal sample pulse
//   S_SYNC  | sample set latched; presents SYNC_BYTE one cycle later
//   S_SEQ   | presenting the sequence number
//   S_DATA  | presenting channel bytes, MSB first, r_idx selects the byte
//   S_CSUM  | presenting the checksum; its transfer ends the frame
// ---------------------------------------------------------------------------
module radiometer_frame_packer #(
    parameter int          N_CH      = 2,
    parameter int          DATA_W    = 12,
    parameter int          DECIM     = 1,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic [N_CH*DATA_W-1:0]   sample_data,
    input  logic                     tx_ready,
    output logic                     tx_valid,
    output logic [7:0]               tx_byte,
    output logic                     frame_busy,
    output logic [15:0]              drop_count
);

    localparam int         DCW      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [3:0] LAST_IDX = 4'(2 * N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_DATA,
        S_CSUM
    } state_t;

    state_t           r_state;
    logic [7:0]       r_seq;
    logic [DCW-1:0]   r_dec_cnt;
    logic [3:0]       r_idx;
    logic [7:0]       r_csum;
    logic [15:0]      r_words [N_CH];
    logic             r_tx_valid;
    logic [7:0]       r_tx_byte;
    logic             r_frame_busy;
    logic [15:0]      r_drop_count;

    logic             w_terminal;
    logic             w_xfer;
    logic [3:0]       w_next_idx;
    logic [7:0]       w_next_byte;

    assign w_terminal = sample_valid && enable && (r_dec_cnt == DCW'(DECIM - 1));
    assign w_xfer     = r_tx_valid && tx_ready;
    assign w_next_idx = r_idx + 4'd1;

    // Byte that follows the current data byte: even index is a channel MSB,
    // odd index the matching LSB.
    always_comb begin
        w_next_byte = 8'h00;
        for (int c = 0; c < N_CH; c++) begin
            if (w_next_idx == 4'(2 * c))
                w_next_byte = r_words[c][15:8];
            if (w_next_idx == 4'(2 * c + 1))
                w_next_byte = r_words[c][7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_seq        <= 8'h00;
            r_dec_cnt    <= '0;
            r_idx        <= 4'd0;
            r_csum       <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_frame_busy <= 1'b0;
            r_drop_count <= 16'h0000;
            for (int c = 0; c < N_CH; c++)
                r_words[c] <= 16'h0000;
        end else begin
            if (sample_valid && enable)
                r_dec_cnt <= w_terminal ? '0 : r_dec_cnt + DCW'(1);

            // Any terminal pulse outside IDLE is a lost sample set, including
            // one coinciding with the checksum transfer.
            if (w_terminal && (r_state != S_IDLE) && (r_drop_count != 16'hFFFF))
                r_drop_count <= r_drop_count + 16'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_terminal) begin
                        for (int c = 0; c < N_CH; c++)
                            r_words[c] <= 16'(sample_data[c*DATA_W +: DATA_W]);
                        r_state      <= S_SYNC;
                        r_frame_busy <= 1'b1;
                    end
                end

                // First cycle here only raises tx_valid; the sync byte then
                // waits for its transfer like every other byte.
                S_SYNC: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_byte  <= SYNC_BYTE;
                    end else if (w_xfer) begin
                        r_state   <= S_SEQ;
                        r_tx_byte <= r_seq;
                    end
                end

                S_SEQ: begin
                    if (w_xfer) begin
                        r_state   <= S_DATA;
                        r_idx     <= 4'd0;
                        r_csum    <= r_tx_byte;
                        r_tx_byte <= r_words[0][15:8];
                    end
                end

                S_DATA: begin
                    if (w_xfer) begin
                        r_csum <= r_csum + r_tx_byte;
                        if (r_idx == LAST_IDX) begin
                            r_state   <= S_CSUM;
                            r_tx_byte <= r_csum + r_tx_byte;
                        end else begin
                            r_idx     <= w_next_idx;
                            r_tx_byte <= w_next_byte;
                        end
                    end
                end

                S_CSUM: begin
                    if (w_xfer) begin
                        r_state      <= S_IDLE;
                        r_tx_valid   <= 1'b0;
                        r_frame_busy <= 1'b0;
                        r_seq        <= r_seq + 8'd1;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_tx_valid   <= 1'b0;
                    r_frame_busy <= 1'b0;
                end
            endcase
        end
    end

    assign tx_valid   = r_tx_valid;
    assign tx_byte    = r_tx_byte;
    assign frame_busy = r_frame_busy;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_radiometer_frame_packer.sv
// ---------------------------------------------------------------------------
// Bench for radiometer_frame_packer. Two instances: dut_a (DECIM=1) and
// dut_b (DECIM=4). Stimulus pushes expected bytes into a per-instance queue;
// a negedge monitor pops and compares on every byte transfer.
// Inputs change 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_radiometer_frame_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        enable_a = 1'b1, sv_a = 1'b0, ready_a = 1'b1;
    logic [23:0] data_a = '0;
    logic        tx_valid_a, frame_busy_a;
    logic [7:0]  tx_byte_a;
    logic [15:0] drop_a;

    logic        enable_b = 1'b1, sv_b = 1'b0, ready_b = 1'b1;
    logic [23:0] data_b = '0;
    logic        tx_valid_b, frame_busy_b;
    logic [7:0]  tx_byte_b;
    logic [15:0] drop_b;

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer_a = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    radiometer_frame_packer #(.N_CH(2), .DATA_W(12), .DECIM(1), .SYNC_BYTE(8'hA5)) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .sample_valid(sv_a),
        .sample_data(data_a), .tx_ready(ready_a), .tx_valid(tx_valid_a),
        .tx_byte(tx_byte_a), .frame_busy(frame_busy_a), .drop_count(drop_a));

    radiometer_frame_packer #(.N_CH(2), .DATA_W(12), .DECIM(4), .SYNC_BYTE(8'hA5)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .sample_valid(sv_b),
        .sample_data(data_b), .tx_ready(ready_b), .tx_valid(tx_valid_b),
        .tx_byte(tx_byte_b), .frame_busy(frame_busy_b), .drop_count(drop_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!reset && tx_valid_a && ready_a) begin
            n_xfer_a++;
            if (qa.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL a_unexpected_byte: got %0h expected none", tx_byte_a);
            end else begin
                chk("a_byte", {24'h0, tx_byte_a}, {24'h0, qa.pop_front()});
            end
        end
        if (!reset && tx_valid_b && ready_b) begin
            if (qb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_unexpected_byte: got %0h expected none", tx_byte_b);
            end else begin
                chk("b_byte", {24'h0, tx_byte_b}, {24'h0, qb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [11:0] c0, input logic [11:0] c1);
        data_a = {c1, c0};
        sv_a   = 1'b1;
        tick();
        sv_a   = 1'b0;
    endtask

    task automatic pulse_b(input logic [11:0] c0, input logic [11:0] c1);
        data_b = {c1, c0};
        sv_b   = 1'b1;
        tick();
        sv_b   = 1'b0;
    endtask

    task automatic push_a(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        qa.push_back(b0); qa.push_back(b1); qa.push_back(b2); qa.push_back(b3);
        qa.push_back(b4); qa.push_back(b5); qa.push_back(b6);
    endtask

    // Frame model used by the long wrap run.
    task automatic push_model_a(input logic [7:0] seq, input logic [11:0] c0, input logic [11:0] c1);
        logic [15:0] w0, w1;
        logic [7:0]  s;
        w0 = {4'h0, c0};
        w1 = {4'h0, c1};
        s  = seq + w0[15:8] + w0[7:0] + w1[15:8] + w1[7:0];
        push_a(8'hA5, seq, w0[15:8], w0[7:0], w1[15:8], w1[7:0], s);
    endtask

    task automatic wait_idle_a(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            tick();
            if (!frame_busy_a && !tx_valid_a) break;
        end
        if (i == 300) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got busy expected idle", name);
        end
    endtask

    initial begin
        int nv;
        int base;
        int i;

        repeat (3) tick();
        chk("rst_tx_valid",   {31'h0, tx_valid_a},   32'h0);
        chk("rst_tx_byte",    {24'h0, tx_byte_a},    32'h0);
        chk("rst_frame_busy", {31'h0, frame_busy_a}, 32'h0);
        chk("rst_drop_count", {16'h0, drop_a},       32'h0);
        reset = 1'b0;
        tick();

        // Decimation on dut_b: frames come from pulses 4 and 8 only.
        qb.push_back(8'hA5); qb.push_back(8'h00); qb.push_back(8'h01); qb.push_back(8'h04);
        qb.push_back(8'h02); qb.push_back(8'h04); qb.push_back(8'h0B);
        qb.push_back(8'hA5); qb.push_back(8'h01); qb.push_back(8'h01); qb.push_back(8'h08);
        qb.push_back(8'h02); qb.push_back(8'h08); qb.push_back(8'h14);
        for (int p = 1; p <= 8; p++) begin
            pulse_b(12'(12'h100 + p), 12'(12'h200 + p));
            repeat (19) tick();
        end
        chk("decim_drop_count", {16'h0, drop_b}, 32'h0);
        chk("decim_queue_left", qb.size(), 0);
        chk("decim_busy", {31'h0, frame_busy_b}, 32'h0);

        // Basic frame, checking latency and an unbroken tx_valid run.
        push_a(8'hA5, 8'h00, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'hEA);
        pulse_a(12'hABC, 12'h123);
        chk("lat_valid_low", {31'h0, tx_valid_a},   32'h0);
        chk("lat_busy_high", {31'h0, frame_busy_a}, 32'h1);
        tick();
        chk("lat_valid_high", {31'h0, tx_valid_a}, 32'h1);
        chk("lat_sync_byte",  {24'h0, tx_byte_a},  32'hA5);
        nv = 1;
        for (i = 0; i < 20; i++) begin
            tick();
            if (tx_valid_a) nv++;
            else break;
        end
        chk("t1_valid_run", nv, 7);
        chk("t1_busy_fall", {31'h0, frame_busy_a}, 32'h0);

        // Backpressure while BC is presented.
        push_a(8'hA5, 8'h01, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'hEB);
        pulse_a(12'hABC, 12'h123);
        for (i = 0; i < 30; i++) begin
            if (tx_valid_a && tx_byte_a == 8'h0A) break;
            tick();
        end
        chk("t2_found_0a", i < 30, 1);
        tick();
        ready_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t2_hold_valid", {31'h0, tx_valid_a}, 32'h1);
            chk("t2_hold_byte",  {24'h0, tx_byte_a},  32'hBC);
        end
        tick();
        ready_a = 1'b1;
        wait_idle_a("t2");

        // Drop: second terminal pulse three cycles into the frame.
        push_a(8'hA5, 8'h02, 8'h05, 8'hA5, 8'h0F, 8'hFF, 8'hBA);
        pulse_a(12'h5A5, 12'hFFF);
        tick();
        tick();
        pulse_a(12'h111, 12'h222);
        wait_idle_a("t3");
        repeat (20) tick();
        chk("t3_drop_count", {16'h0, drop_a}, 32'h1);
        chk("t3_no_second",  {31'h0, tx_valid_a}, 32'h0);
        chk("t3_queue_left", qa.size(), 0);

        // Reset while DATA byte 2 is presented.
        qa.push_back(8'hA5); qa.push_back(8'h03); qa.push_back(8'h00); qa.push_back(8'hAB);
        base = n_xfer_a;
        pulse_a(12'h0AB, 12'h0CD);
        for (i = 0; i < 50; i++) begin
            if (n_xfer_a >= base + 4) break;
            tick();
        end
        chk("t6_reached_data2", i < 50, 1);
        reset = 1'b1;
        tick();
        chk("t6_valid",  {31'h0, tx_valid_a},   32'h0);
        chk("t6_busy",   {31'h0, frame_busy_a}, 32'h0);
        chk("t6_drop",   {16'h0, drop_a},       32'h0);
        chk("t6_queue_left", qa.size(), 0);
        reset = 1'b0;
        tick();
        push_a(8'hA5, 8'h00, 8'h01, 8'h23, 8'h04, 8'h56, 8'h7E);
        pulse_a(12'h123, 12'h456);
        wait_idle_a("t6_next");

        // Sequence wrap: frames seq 01..FF then 00 follow the seq 00 frame.
        for (int k = 1; k <= 256; k++) begin
            logic [11:0] c0, c1;
            c0 = 12'(k * 37);
            c1 = 12'(k * 91 + 5);
            push_model_a(8'(k), c0, c1);
            pulse_a(c0, c1);
            wait_idle_a("wrap");
        end
        chk("wrap_queue_left", qa.size(), 0);
        chk("wrap_drop", {16'h0, drop_a}, 32'h0);

        // Drop saturation against a stalled frame.
        ready_a = 1'b0;
        pulse_a(12'h001, 12'h002);
        data_a = 24'h0;
        sv_a   = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", {16'h0, drop_a}, 32'hFFFE);
        repeat (3) tick();
        sv_a = 1'b0;
        tick();
        chk("sat_ffff",       {16'h0, drop_a},    32'hFFFF);
        chk("sat_hold_valid", {31'h0, tx_valid_a}, 32'h1);
        chk("sat_hold_byte",  {24'h0, tx_byte_a},  32'hA5);
        chk("sat_queue_left", qa.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
